// File: rtl/cra_pkg.sv
// cra_pkg: shared constants and elaboration checks for the pipelined carry-ripple adder
package cra_pkg;
  localparam logic SUB_OP = 1'b1;
  // A width splits cleanly only when every stage gets an equal, non-empty chunk.
  function automatic bit chunk_ok(input int n, input int stages);
    return stages >= 1 && stages <= n && (n % stages) == 0;
  endfunction
endpackage

// File: rtl/cra_chunk.sv
// cra_chunk: combinational W-bit ripple-carry adder built from full-adder bits
module cra_chunk #(
  parameter int W = 8
) (
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         cout
);
  logic c;
  // Ripple the carry through one full adder per bit.
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/cra_pipe.sv
// cra_pipe: pipelined carry-ripple adder/subtractor, one chunk per stage, valid/ready flow control
module cra_pipe
  import cra_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);
  localparam int W = N / STAGES;

  if (!chunk_ok(N, STAGES)) begin : g_bad
    $error("cra_pipe: N must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0] v, c, rdy, uv, uc, co;
  logic [N-1:0]      sr [STAGES];
  logic [N-1:0]      ar [STAGES];
  logic [N-1:0]      br [STAGES];
  logic [N-1:0]      us [STAGES];
  logic [N-1:0]      ua [STAGES];
  logic [N-1:0]      ub [STAGES];
  logic [N-1:0]      ns [STAGES];
  logic [W-1:0]      cs [STAGES];
  logic              full;

  // Upstream view of every stage: stage 0 sees the (conditioned) inputs, others their predecessor.
  always_comb begin
    uv[0] = in_valid;
    uc[0] = sub == SUB_OP ? ~cin : cin;
    ua[0] = a;
    ub[0] = sub == SUB_OP ? ~b : b;
    us[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      uv[k] = v[k-1];
      uc[k] = c[k-1];
      ua[k] = ar[k-1];
      ub[k] = br[k-1];
      us[k] = sr[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    cra_chunk #(.W(W)) u_chunk (
      .cin  (uc[k]),
      .a    (ua[k][k*W +: W]),
      .b    (ub[k][k*W +: W]),
      .s    (cs[k]),
      .cout (co[k])
    );
  end

  // Each stage passes the lower sum chunks along and fills in its own chunk.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ns[k] = us[k];
      ns[k][k*W +: W] = cs[k];
    end
  end

  // A stage can load unless it and every stage downstream is full and the consumer stalls.
  always_comb begin
    full = 1'b1;
    rdy  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full && v[k];
      rdy[k] = out_ready || !full;
    end
  end

  // Stage registers: load from upstream when ready (collapsing bubbles), otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sr[k] <= '0;
        ar[k] <= '0;
        br[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k]  <= uv[k];
          c[k]  <= co[k];
          sr[k] <= ns[k];
          ar[k] <= ua[k];
          br[k] <= ub[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign s         = sr[STAGES-1];
  assign cout      = c[STAGES-1];
  assign ovf       = (ar[STAGES-1][N-1] == br[STAGES-1][N-1]) && (sr[STAGES-1][N-1] != ar[STAGES-1][N-1]);
endmodule

// File: tb/tb_cra_pipe.sv
// tb_cra_pipe: randomized and directed checks of cra_pipe at STAGES = 4, 1 and 32
module tb_cra_pipe;
  localparam int ST [3] = '{4, 1, 32};

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        md;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic [2:0]  iv = '0, ordy = '0, irdy, ov, co, of;
  logic [31:0] so [3];

  int          n_cmp = 0, n_err = 0, cnt = 0;
  logic [33:0] q [$];
  logic [33:0] e;
  vec_t        dv [6];

  always #5 clk = ~clk;

  cra_pipe #(.N(32), .STAGES(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .s(so[0]), .cout(co[0]), .ovf(of[0]));
  cra_pipe #(.N(32), .STAGES(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .s(so[1]), .cout(co[1]), .ovf(of[1]));
  cra_pipe #(.N(32), .STAGES(32)) u_p32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(ordy[2]), .s(so[2]), .cout(co[2]), .ovf(of[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on 64-bit values; returns {ovf, cout, s}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic md);
    longint ux, uy, sx, sy, r, u;
    logic   cy, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = md ? sx - sy - longint'(c) : sx + sy + longint'(c);
    u  = md ? ux - uy - longint'(c) : ux + uy + longint'(c);
    cy = md ? (ux >= uy + longint'(c)) : (u > longint'(32'hFFFFFFFF));
    v  = (r > longint'(32'h7FFFFFFF)) || (r < -longint'(32'h80000000));
    return {v, cy, u[31:0]};
  endfunction

  task automatic load_rand();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Scoreboard for the STAGES=4 instance: in-order results, occupancy-based in_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt = 0;
    end else begin
      check("in_ready", irdy[0], (cnt < 4) || ordy[0]);
      if (ov[0] && ordy[0]) begin
        check("stream_nonempty", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("stream_s", so[0], e[31:0]);
          check("stream_cout", co[0], e[32]);
          check("stream_ovf", of[0], e[33]);
        end
      end
      if (iv[0] && irdy[0]) q.push_back(model(a, b, cin, sub));
      cnt = cnt + int'(iv[0] && irdy[0]) - int'(ov[0] && ordy[0]);
    end
  end

  task automatic directed(input vec_t t);
    int lat [3];
    lat = '{0, 0, 0};
    @(posedge clk); #1;
    a = t.a; b = t.b; cin = t.c; sub = t.md; iv = 3'b111; ordy = 3'b111;
    @(posedge clk); #1;
    iv = 3'b000;
    for (int cyc = 1; cyc <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && lat[d] == 0) begin
          lat[d] = cyc;
          check("dir_s", so[d], t.s);
          check("dir_cout", co[d], t.co);
          check("dir_ovf", of[d], t.ov);
        end
      end
    end
    for (int d = 0; d < 3; d++) check("dir_latency", lat[d], ST[d]);
  endtask

  task automatic stream(input int n, input int hold, input bit rnd);
    int          sent, cyc;
    bit          acc;
    logic [31:0] held;
    sent = 0;
    cyc  = 0;
    held = '0;
    iv[2:1] = 2'b00;
    ordy[2:1] = 2'b11;
    @(posedge clk); #1;
    iv[0] = 1'b1;
    load_rand();
    while ((sent < n || q.size() != 0) && cyc < 3000) begin
      ordy[0] = cyc < hold ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      @(negedge clk);
      acc = iv[0] && irdy[0];
      if (hold > 0 && cyc == hold / 2) held = so[0];
      if (hold > 0 && cyc == hold - 1) begin
        check("hold_accepted", sent + int'(acc), 4);
        check("hold_valid", ov[0], 1);
        check("hold_stable", so[0], held);
      end
      if (hold > 0 && cyc >= hold && cyc < hold + 4) check("drain_rate", ov[0], 1);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < n) load_rand();
        else iv[0] = 1'b0;
      end
    end
    check("stream_sent", sent, n);
    check("stream_drained", q.size(), 0);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit stale;
    dv[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    dv[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    dv[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    dv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    dv[4] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    dv[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset_valid", ov[d], 0);
      check("reset_s", so[d], 0);
      check("reset_cout", co[d], 0);
      check("reset_ovf", of[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", irdy, 3'b111);

    for (int i = 0; i < 6; i++) directed(dv[i]);

    stream(16, 0, 1'b1);
    stream(6, 10, 1'b0);

    @(posedge clk); #1;
    ordy = 3'b111;
    iv = 3'b111;
    for (int i = 0; i < 3; i++) begin
      load_rand();
      @(posedge clk); #1;
    end
    iv = 3'b000;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("midrst_valid", ov[d], 0);
      check("midrst_s", so[d], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      stale = stale | (|ov);
    end
    check("no_stale", stale, 0);
    check("ready_after_midrst", irdy, 3'b111);

    for (int i = 0; i < 6; i++) directed(dv[i]);
    stream(16, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cra_pipe.md
Name: cra_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width carry-ripple adders.
- An N-bit operand pair is split into STAGES equal chunks. Each chunk ripples through one pipeline stage, and the carry is registered between stages.
- Adds add/subtract mode, signed overflow, and valid/ready flow control with bubble collapsing.
- Sits on datapaths that need wide adders at high clock rate, where a combinational N-bit ripple would limit timing.

Parameters:
- N, 32, operand/sum width in bits. N % STAGES must be 0; elaboration fails otherwise.
- STAGES, 4, number of pipeline stages (1..N). Chunk width W = N/STAGES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- s  out  N  sum/difference
- cout  out  1  raw carry out of bit N-1
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous): every stage valid flop and every data flop clears to 0. Outputs are out_valid=0, s=0, cout=0, ovf=0. in_ready comes back 1 once reset is released.
- Arithmetic:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~cin : cin.
  - Result {cout, s} = a + b_eff + c_eff.
  - sub=1, cin=0 gives a-b. sub=1, cin=1 gives a-b-1.
  - In sub mode cout=1 means no borrow.
  - ovf = (a[N-1] == b_eff[N-1]) && (s[N-1] != a[N-1]).
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - in_valid, a, b, cin and sub may change only after acceptance; values on non-accepted cycles are ignored.
- Pipeline (stage k = 0..STAGES-1):
  - Each stage holds: valid_k, carry_k, lower sum chunks [0..k], remaining upper chunks of a and b_eff, and a[N-1] / b_eff[N-1] for ovf.
  - Stage 0 computes chunk 0 from the inputs and c_eff.
  - Stage k>0 computes chunk k from its held operands and carry_{k-1}.
  - The last stage drives s, cout and ovf straight from its registers. Outputs are registered, not combinational.
- Flow control:
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready. in_ready = ready_0.
  - A stage loads from upstream when ready_k; its valid becomes the upstream valid. Bubbles collapse.
  - Stalled stages hold all contents.
- Latency: exactly STAGES cycles from acceptance to out_valid when unstalled. Throughput is one result per cycle.
- Boundaries:
  - out_ready held low: the pipeline fills to STAGES entries, then in_ready=0. No data is lost or duplicated.
  - Simultaneous accept at the input and drain at the output when full: both occur, and occupancy is unchanged.
  - STAGES=1: a single registered full adder with the same handshake.
  - STAGES=N: one bit per stage.
  - Carry crossing every chunk boundary (e.g. all-ones + 1) must propagate correctly across all stages.
  - Reset mid-operation: all in-flight results are discarded, with no output valid on the cycle after release.

Decomposition:
- Package cra_pkg holds a localparam function checking N % STAGES, and the constant SUB_OP=1'b1.
- One sub-module, cra_chunk: a combinational W-bit ripple adder with ports cin, a, b, s, cout, built from full-adder bits. Each stage instantiates it once via generate.
- cra_pipe holds only registers and handshake logic.

Test Plan:
- N=32, STAGES=4: a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0 → after 4 cycles s=0x0000_0000, cout=1, ovf=0.
- sub=1: a=5, b=7, cin=0 → s=0xFFFF_FFFE, cout=0, ovf=0. Same with a=0x8000_0000, b=1 → s=0x7FFF_FFFF, cout=1, ovf=1.
- Overflow on add: a=0x7FFF_FFFF, b=1 → s=0x8000_0000, ovf=1, cout=0. Borrow-in: sub=1, cin=1, a=10, b=3 → s=6.
- Back-to-back stream of 16 random pairs with out_ready toggling pseudo-randomly → all 16 results match the reference model, in order, none lost or duplicated. in_ready=0 only when 4 entries are held.
- Hold out_ready=0 for 10 cycles while driving 6 inputs → exactly 4 accepted, out_valid=1 with the first result held stable. Release → remaining results drain at 1 per cycle.
- Assert rst_n=0 for 1 cycle with 3 results in flight → out_valid=0, s=0 immediately. No stale results after release. Repeat the directed cases with STAGES=1 and STAGES=32.
